apb_cmd_master: RTL and testbench

- APB initiator: turns single-beat commands from a valid/ready command channel into APB setup/access transfers.
- Returns read data and error status on a valid/ready response channel.
- Drives the SPI controller's APB register slave from a bring-up sequencer or DMA-style core, with no CPU involved.
- One transfer outstanding at a time; response buffered until consumed.

---
 rtl/apb_cmd_master.sv | 189 ++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB initiator driven by a valid/ready
// command channel, returning read data / error on a valid/ready response
// channel. The response is held until consumed; a new command may be
// accepted on the same cycle the response is taken.
//
// Build option: define APB_CMD_TIMEOUT_EN to abort ACCESS phases that wait
// TIMEOUT_CYCLES cycles without PREADY. Without it ACCESS waits forever and
// rsp_timeout is tied low.
//
// state  | meaning
// IDLE   | no transfer, cmd_ready high
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY
// RESP   | response held on rsp_* until rsp_ready
module apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_accept;
  logic                      w_complete;
  logic                      w_tmo;
  logic [1:0]                w_unused_addr_lsb;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_pwrite;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_busy;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;

  // Word access only: the byte-lane bits of the command address are dropped.
  assign w_unused_addr_lsb = cmd_addr[1:0];

  assign cmd_ready  = (r_state == ST_IDLE) | ((r_state == ST_RESP) & rsp_ready);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_complete = (r_state == ST_ACCESS) & PREADY;

`ifdef APB_CMD_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_rsp_timeout;

  // A completing PREADY on the limit cycle wins, hence the !PREADY term.
  assign w_tmo = (r_state == ST_ACCESS) & ~PREADY &
                 (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Wait counter: held at zero outside ACCESS, counts stalled ACCESS cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wait_cnt <= 16'd0;
    end else if (r_state != ST_ACCESS) begin
      r_wait_cnt <= 16'd0;
    end else if (!PREADY) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Timeout flag of the held response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_tmo       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (PREADY || w_tmo) w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = cmd_valid ? ST_SETUP : ST_IDLE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // APB strobes, busy and rsp_valid registered from the next state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_psel      <= (w_next == ST_SETUP) | (w_next == ST_ACCESS);
      r_penable   <= (w_next == ST_ACCESS);
      r_busy      <= (w_next == ST_SETUP) | (w_next == ST_ACCESS);
      r_rsp_valid <= (w_next == ST_RESP);
    end
  end

  // Command capture; address/data/direction hold until the next accept.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_paddr  <= '0;
      r_pwdata <= 32'd0;
      r_pwrite <= 1'b0;
    end else if (w_accept) begin
      r_paddr  <= {cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
      r_pwdata <= cmd_wdata;
      r_pwrite <= cmd_write;
    end
  end

  // Response capture at completion or abort; held stable in RESP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_complete) begin
      r_rsp_rdata <= r_pwrite ? 32'd0 : PRDATA;
      r_rsp_err   <= PSLVERR;
    end else if (w_tmo) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b1;
    end
  end

  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a vector table of single transfers plus
// hand-written sequences for latency, backpressure, reset and timeout.
module tb_apb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR, busy;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  apb_cmd_master #(.APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          wait_n;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // One transfer from IDLE, with wait_n stalled ACCESS cycles.
  task automatic do_xfer(input vec_t v, input int idx);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0; rsp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d cmd_ready_idle", idx), {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'h0;
    chk($sformatf("v%0d setup_strobes", idx), {30'd0, PSEL, PENABLE}, 32'd2);
    chk($sformatf("v%0d setup_paddr", idx), PADDR, v.exp_paddr);
    chk($sformatf("v%0d setup_pwrite", idx), {31'd0, PWRITE}, {31'd0, v.wr});
    tick();
    for (int i = 0; i < v.wait_n; i++) begin
      chk($sformatf("v%0d wait%0d_strobes", idx, i), {30'd0, PSEL, PENABLE}, 32'd3);
      chk($sformatf("v%0d wait%0d_paddr", idx, i), PADDR, v.exp_paddr);
      chk($sformatf("v%0d wait%0d_pwdata", idx, i), PWDATA, v.wdata);
      tick();
    end
    PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
    chk($sformatf("v%0d access_strobes", idx), {30'd0, PSEL, PENABLE}, 32'd3);
    tick();
    PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF; PSLVERR = 1'b0;
    chk($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d resp_psel", idx), {30'd0, PSEL, PENABLE}, 32'd0);
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d rsp_timeout", idx), {31'd0, rsp_timeout}, 32'd0);
    chk($sformatf("v%0d cmd_ready_resp", idx), {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_consumed", idx), {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t lv;
    logic [5:0] exp_psel;
    logic [5:0] exp_rv;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0, 0, 32'h0000_0004, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0023, 32'h0000_0000, 32'h1234_5678, 1'b0, 3, 32'h0000_0020, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 0, 32'h0000_0014, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0F0F_F0F0, 32'h5A5A_5A5A, 1'b1, 2, 32'hFFFF_FFFC, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_03FE, 32'h0000_0000, 32'h8000_0001, 1'b0, 6, 32'h0000_03FC, 32'h8000_0001, 1'b0};

    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick(); tick();
    chk("reset_strobes", {28'd0, PSEL, PENABLE, rsp_valid, busy}, 32'd0);
    chk("reset_paddr", PADDR, 32'd0);
    chk("reset_pwdata", PWDATA, 32'd0);
    chk("reset_rsp", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    HRESET = 1'b0;
    tick();
    chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Latency: write with PREADY tied high.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h04; cmd_wdata = 32'hA5A5_0001;
    PREADY = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("lat_c0_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("lat_c1_strobes", {29'd0, PSEL, PENABLE, busy}, 32'h5);
    chk("lat_c1_paddr", PADDR, 32'h04);
    chk("lat_c1_pwdata", PWDATA, 32'hA5A5_0001);
    chk("lat_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lat_c2_strobes", {29'd0, PSEL, PENABLE, busy}, 32'h7);
    tick();
    chk("lat_c3_strobes", {29'd0, PSEL, PENABLE, busy}, 32'h0);
    chk("lat_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_c3_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("lat_c3_rdata", rsp_rdata, 32'd0);
    tick();
    chk("lat_c4_idle", {30'd0, rsp_valid, PSEL}, 32'd0);
    PREADY = 1'b0; rsp_ready = 1'b0;

    for (int k = 0; k < 6; k++) begin
      do_xfer(vecs[k], k);
    end

`ifndef APB_CMD_TIMEOUT_EN
    // Without the timeout option a long stall must simply be waited out.
    lv = '{1'b0, 32'h0000_0100, 32'h0, 32'h3C3C_C3C3, 1'b0, 20, 32'h0000_0100, 32'h3C3C_C3C3, 1'b0};
    do_xfer(lv, 6);
`endif

    // Response backpressure with a second command pending, then streaming.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
    PREADY = 1'b1; PRDATA = 32'h1111_2222; PSLVERR = 1'b0; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h5555_0044;
    PRDATA = 32'h9999_9999; PSLVERR = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d rsp_rdata", i), rsp_rdata, 32'h1111_2222);
      chk($sformatf("bp%0d rsp_err", i), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("bp%0d cmd_ready", i), {31'd0, cmd_ready}, 32'd0);
      chk($sformatf("bp%0d psel", i), {31'd0, PSEL}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
    #1;
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_write = 1'b0; cmd_addr = 32'h48;
    exp_psel = 6'b011011;
    exp_rv   = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream%0d psel", i), {31'd0, PSEL}, {31'd0, exp_psel[i]});
      chk($sformatf("stream%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, exp_rv[i]});
      if (i == 0) begin
        chk("stream_b_paddr", PADDR, 32'h44);
        chk("stream_b_pwrite", {31'd0, PWRITE}, 32'd1);
        chk("stream_b_pwdata", PWDATA, 32'h5555_0044);
      end
      if (i == 2) begin
        chk("stream_b_rdata", rsp_rdata, 32'd0);
        chk("stream_b_err", {31'd0, rsp_err}, 32'd0);
      end
      if (i == 3) begin
        chk("stream_c_paddr", PADDR, 32'h48);
        chk("stream_c_pwrite", {31'd0, PWRITE}, 32'd0);
        cmd_valid = 1'b0;
        PRDATA = 32'h0000_C0C0;
      end
      if (i == 5) begin
        chk("stream_c_rdata", rsp_rdata, 32'h0000_C0C0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stream_end%0d", i), {30'd0, PSEL, rsp_valid}, 32'd0);
      tick();
    end
    rsp_ready = 1'b0; PREADY = 1'b0;

    // Reset in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst_mid_strobes", {28'd0, PSEL, PENABLE, rsp_valid, busy}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_mid_paddr", PADDR, 32'd0);
    PREADY = 1'b1; PRDATA = 32'h7777_7777;
    tick();
    tick();
    chk("rst_mid_no_rsp", {30'd0, rsp_valid, PSEL}, 32'd0);
    PREADY = 1'b0;

`ifdef APB_CMD_TIMEOUT_EN
    // PREADY stuck low: exactly 8 ACCESS cycles, then an aborted response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h90; PRDATA = 32'hABCD_EF01;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo_access%0d", i), {30'd0, PSEL, PENABLE}, 32'd3);
      tick();
    end
    chk("tmo_strobes", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd3);
    chk("tmo_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // PREADY arrives on the 8th ACCESS cycle: normal completion wins.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h94; PRDATA = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("lim_access%0d", i), {30'd0, PSEL, PENABLE}, 32'd3);
      tick();
    end
    PREADY = 1'b1; PRDATA = 32'h0000_0077;
    chk("lim_access7", {30'd0, PSEL, PENABLE}, 32'd3);
    tick();
    PREADY = 1'b0;
    chk("lim_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lim_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    chk("lim_rdata", rsp_rdata, 32'h0000_0077);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
